// File: rtl/csr_access_unit.sv
// Zicsr execution unit: reads a CSR, computes the new value, writes it back
// when required, and returns the old value (or an illegal-instruction flag).
module csr_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rd_idx,
    input  logic            flush,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_ro,
    input  logic            csr_rexc,
    output logic            csr_wvalid,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd_idx,
    output logic [XLEN-1:0] rsp_rd_data,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [4:0]      rd_idx_q;
    logic [XLEN-1:0] old_q;

    logic            req_ready_q;
    logic [11:0]     csr_raddr_q;
    logic            csr_wvalid_q;
    logic [11:0]     csr_waddr_q;
    logic [XLEN-1:0] csr_wdata_q;
    logic            rsp_valid_q;
    logic [4:0]      rsp_rd_idx_q;
    logic [XLEN-1:0] rsp_rd_data_q;
    logic            rsp_illegal_q;

    logic [XLEN-1:0] operand_d;
    logic [XLEN-1:0] wdata_d;
    logic            do_write_d;
    logic            illegal_d;

    // Read-modify-write datapath, evaluated while the CSR read is in progress
    always_comb begin
        operand_d  = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_data_q;
        wdata_d    = csr_rdata;
        case (funct3_q[1:0])
            2'b01:   wdata_d = operand_d;
            2'b10:   wdata_d = csr_rdata | operand_d;
            2'b11:   wdata_d = csr_rdata & ~operand_d;
            default: wdata_d = csr_rdata;
        endcase
        do_write_d = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        illegal_d  = (funct3_q[1:0] == 2'b00) || csr_rexc || (do_write_d && csr_ro);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            funct3_q      <= 3'd0;
            rs1_idx_q     <= 5'd0;
            rs1_data_q    <= '0;
            rd_idx_q      <= 5'd0;
            old_q         <= '0;
            req_ready_q   <= 1'b1;
            csr_raddr_q   <= 12'd0;
            csr_wvalid_q  <= 1'b0;
            csr_waddr_q   <= 12'd0;
            csr_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_idx_q  <= 5'd0;
            rsp_rd_data_q <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            csr_wvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        funct3_q    <= req_funct3;
                        csr_raddr_q <= req_addr;
                        rs1_idx_q   <= req_rs1_idx;
                        rs1_data_q  <= req_rs1_data;
                        rd_idx_q    <= req_rd_idx;
                        req_ready_q <= 1'b0;
                        state_q     <= S_READ;
                    end
                end
                S_READ: begin
                    if (flush) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        old_q        <= csr_rdata;
                        rsp_rd_idx_q <= rd_idx_q;
                        if (do_write_d && !illegal_d) begin
                            csr_wvalid_q <= 1'b1;
                            csr_waddr_q  <= csr_raddr_q;
                            csr_wdata_q  <= wdata_d;
                            state_q      <= S_WRITE;
                        end else begin
                            rsp_valid_q   <= 1'b1;
                            rsp_illegal_q <= illegal_d;
                            rsp_rd_data_q <= illegal_d ? '0 : csr_rdata;
                            state_q       <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    rsp_valid_q   <= 1'b1;
                    rsp_illegal_q <= 1'b0;
                    rsp_rd_data_q <= old_q;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    // Response fields hold until writeback takes them
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign csr_raddr   = csr_raddr_q;
    assign csr_wvalid  = csr_wvalid_q;
    assign csr_waddr   = csr_waddr_q;
    assign csr_wdata   = csr_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd_idx  = rsp_rd_idx_q;
    assign rsp_rd_data = rsp_rd_data_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized bench for csr_access_unit against a behavioural Zicsr model,
// with a simple CSR file model providing read data and absorbing writes.
module tb_csr_access_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [4:0]      req_rs1_idx;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rd_idx;
    logic            flush;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_ro;
    logic            csr_rexc;
    logic            csr_wvalid;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [4:0]      rsp_rd_idx;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_illegal;

    logic [XLEN-1:0] mem [4096];
    logic            rexc_r;
    int              wcnt = 0;
    int              n_vec = 0;
    int              n_err = 0;

    csr_access_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
        .req_rd_idx(req_rd_idx), .flush(flush),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_ro(csr_ro), .csr_rexc(csr_rexc),
        .csr_wvalid(csr_wvalid), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_idx(rsp_rd_idx),
        .rsp_rd_data(rsp_rd_data), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // CSR file model: addresses with [11:10]==11 are read-only
    assign csr_rdata = mem[csr_raddr];
    assign csr_ro    = (csr_raddr[11:10] == 2'b11);
    assign csr_rexc  = rexc_r;

    always @(posedge clk) begin
        if (csr_wvalid) begin
            mem[csr_waddr] <= csr_wdata;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural Zicsr semantics
    function automatic void model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                                  input logic [XLEN-1:0] data, input logic [XLEN-1:0] old, input bit rx,
                                  output bit wr, output logic [XLEN-1:0] wd, output bit ill);
        logic [XLEN-1:0] opnd;
        bit wants, ro;
        opnd = (f3 >= 3'd4) ? {27'd0, rs1} : data;
        ro   = (a >= 12'hC00);
        case (f3)
            3'd1, 3'd5: wd = opnd;
            3'd2, 3'd6: wd = old | opnd;
            3'd3, 3'd7: wd = old & ~opnd;
            default:    wd = old;
        endcase
        wants = (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
        ill   = (f3 == 3'd0) || (f3 == 3'd4) || rx || (wants && ro);
        wr    = wants && !ill;
    endfunction

    task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                      input logic [XLEN-1:0] d, input logic [4:0] rd, input bit rx,
                      input int hold, input bit fl);
        logic [XLEN-1:0] old, wd;
        bit wr, ill;
        int w0;
        old = mem[a];
        model(f3, a, rs1, d, old, rx, wr, wd, ill);
        @(negedge clk);
        w0 = wcnt;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_idx = rs1;
        req_rs1_data = d; req_rd_idx = rd; rexc_r = rx;
        @(negedge clk);
        req_valid = 1'b0; req_rs1_data = $urandom; req_addr = 12'($urandom);
        req_rs1_idx = 5'($urandom); req_rd_idx = 5'($urandom);
        chk("raddr", 32'(csr_raddr), 32'(a));
        chk("ready_busy", 32'(req_ready), 32'd0);
        if (fl) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("flush_wvalid", 32'(csr_wvalid), 32'd0);
            chk("flush_rsp", 32'(rsp_valid), 32'd0);
            chk("flush_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            chk("flush_nowrite", 32'(wcnt - w0), 32'd0);
            return;
        end
        @(negedge clk);
        chk("wvalid_c2", 32'(csr_wvalid), 32'(wr));
        if (wr) begin
            chk("waddr", 32'(csr_waddr), 32'(a));
            chk("wdata", csr_wdata, wd);
            chk("rsp_early", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("wvalid_c3", 32'(csr_wvalid), 32'd0);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_idx", 32'(rsp_rd_idx), 32'(rd));
        chk("rd_data", rsp_rd_data, ill ? '0 : old);
        chk("illegal", 32'(rsp_illegal), 32'(ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_rd_data, ill ? '0 : old);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("write_count", 32'(wcnt - w0), 32'(wr));
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wvalid", 32'(csr_wvalid), 32'd0);
        chk("rst_raddr", 32'(csr_raddr), 32'd0);
        chk("rst_waddr", 32'(csr_waddr), 32'd0);
        chk("rst_wdata", csr_wdata, '0);
        chk("rst_rd_idx", 32'(rsp_rd_idx), 32'd0);
        chk("rst_rd_data", rsp_rd_data, '0);
        chk("rst_illegal", 32'(rsp_illegal), 32'd0);
    endtask

    logic [11:0] addrs [8];

    initial begin
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hC00, 12'hF11, 12'h7C0};
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_addr = 12'd0; req_rs1_idx = 5'd0;
        req_rs1_data = '0; req_rd_idx = 5'd0; flush = 1'b0; rsp_ready = 1'b0; rexc_r = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        mem[12'h305] = 32'h0;
        op(3'b001, 12'h305, 5'd5, 32'h100, 5'd1, 1'b0, 0, 1'b0);
        chk("csrrw_mem", mem[12'h305], 32'h100);
        mem[12'h342] = 32'hB;
        op(3'b010, 12'h342, 5'd0, 32'hDEAD, 5'd2, 1'b0, 0, 1'b0);
        mem[12'h341] = 32'hFF;
        op(3'b111, 12'h341, 5'hF, 32'h0, 5'd3, 1'b0, 0, 1'b0);
        chk("csrrci_mem", mem[12'h341], 32'hF0);
        op(3'b001, 12'hF11, 5'd7, 32'h55, 5'd4, 1'b0, 0, 1'b0);
        op(3'b100, 12'h300, 5'd1, 32'h0, 5'd5, 1'b0, 0, 1'b0);
        op(3'b010, 12'h300, 5'd3, 32'h8, 5'd6, 1'b0, 3, 1'b0);
        op(3'b001, 12'h305, 5'd9, 32'h77, 5'd0, 1'b1, 1, 1'b0);
        op(3'b001, 12'h305, 5'd5, 32'h1234, 5'd7, 1'b0, 0, 1'b1);

        // Flush while idle must block acceptance
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_block", 32'(req_ready), 32'd1);
        req_valid = 1'b0; flush = 1'b0;

        // Reset while in WRITE
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_rs1_idx = 5'd2;
        req_rs1_data = 32'hCAFE; req_rd_idx = 5'd8; rexc_r = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_wvalid", 32'(csr_wvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            op(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 7)],
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               $urandom, 5'($urandom), ($urandom_range(0, 9) == 0),
               $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
